// File: rtl/i2s_rx.sv
// I2S receiver: deserialises left/right slots into a stereo pair with a valid/ready handshake.
// Define I2S_RX_FRAME_CHECK_EN to enable slot-length checking and the frame_err pulse.
module i2s_rx #(
    parameter int AUDIO_DW  = 24,
    parameter int SLOT_BITS = 32
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                lrclk,
    input  logic                sdata,
    output logic [AUDIO_DW-1:0] left_chan,
    output logic [AUDIO_DW-1:0] right_chan,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    output logic                frame_err
);

    localparam int CW = $clog2(AUDIO_DW + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(AUDIO_DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(AUDIO_DW - 1);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    state_t              state_q, state_d;
    logic                lrclk_q, lrclk_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [AUDIO_DW-1:0] shift_q, shift_d;
    logic [AUDIO_DW-1:0] left_hold_q, left_hold_d;
    logic                left_have_q, left_have_d;
    logic                frame_done_q, frame_done_d;
    logic [AUDIO_DW-1:0] left_chan_q, left_chan_d;
    logic [AUDIO_DW-1:0] right_chan_q, right_chan_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q, overrun_d;
    logic                lr_edge;
    logic                slot_err;
    logic                load;
    logic [AUDIO_DW-1:0] shifted;

`ifdef I2S_RX_FRAME_CHECK_EN
    localparam int SW = $clog2(SLOT_BITS + 2);
    localparam logic [SW-1:0] SLOT_LEN = SW'(SLOT_BITS);

    logic [SW-1:0] slot_cnt_q, slot_cnt_d;
    logic          frame_err_q, frame_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        lrclk_d      = lrclk;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        left_hold_d  = left_hold_q;
        left_have_d  = left_have_q;
        frame_done_d = 1'b0;
        left_chan_d  = left_chan_q;
        right_chan_d = right_chan_q;
        out_valid_d  = out_valid_q;
        overrun_d    = overrun_q;
        lr_edge      = (lrclk != lrclk_q);
        shifted      = {shift_q[AUDIO_DW-2:0], sdata};
        slot_err     = 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
        frame_err_d = 1'b0;
        slot_cnt_d  = slot_cnt_q;
        if (lr_edge) begin
            slot_cnt_d = SW'(1);
        end else if (slot_cnt_q <= SLOT_LEN) begin
            slot_cnt_d = slot_cnt_q + SW'(1);
        end
        if (state_q != SYNC) begin
            slot_err = lr_edge ? (slot_cnt_q != SLOT_LEN) : (slot_cnt_q == SLOT_LEN);
        end
        frame_err_d = slot_err;
`endif

        if (slot_err) begin
            state_d     = SYNC;
            left_have_d = 1'b0;
            bit_cnt_d   = '0;
        end else begin
            case (state_q)
                SYNC: begin
                    left_have_d = 1'b0;
                    if (lr_edge && !lrclk) begin
                        state_d   = LEFT;
                        bit_cnt_d = '0;
                    end
                end
                LEFT, RIGHT: begin
                    // The sdata seen at the edge-detect posedge is the I2S delay bit and is dropped.
                    if (lr_edge) begin
                        state_d   = lrclk ? RIGHT : LEFT;
                        bit_cnt_d = '0;
                    end else if (bit_cnt_q < CNT_MAX) begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + CW'(1);
                        if (bit_cnt_q == CNT_LAST) begin
                            if (state_q == LEFT) begin
                                left_hold_d = shifted;
                                left_have_d = 1'b1;
                            end else begin
                                frame_done_d = left_have_q;
                            end
                        end
                    end
                end
                default: state_d = SYNC;
            endcase
        end

        // shift_q still holds the right word here: the next lrclk edge cannot precede this load.
        load = frame_done_q && !slot_err && (!out_valid_q || out_ready);
        if (load) begin
            left_chan_d  = left_hold_q;
            right_chan_d = shift_q;
            out_valid_d  = 1'b1;
        end else begin
            if (frame_done_q && !slot_err) begin
                overrun_d = 1'b1;
            end
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q      <= SYNC;
            lrclk_q      <= 1'b1;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            left_hold_q  <= '0;
            left_have_q  <= 1'b0;
            frame_done_q <= 1'b0;
            left_chan_q  <= '0;
            right_chan_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef I2S_RX_FRAME_CHECK_EN
            slot_cnt_q   <= '0;
            frame_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lrclk_q      <= lrclk_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            left_hold_q  <= left_hold_d;
            left_have_q  <= left_have_d;
            frame_done_q <= frame_done_d;
            left_chan_q  <= left_chan_d;
            right_chan_q <= right_chan_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
`ifdef I2S_RX_FRAME_CHECK_EN
            slot_cnt_q   <= slot_cnt_d;
            frame_err_q  <= frame_err_d;
`endif
        end
    end

    assign left_chan  = left_chan_q;
    assign right_chan = right_chan_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;
`ifdef I2S_RX_FRAME_CHECK_EN
    assign frame_err  = frame_err_q;
`else
    assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed self-checking bench for i2s_rx (AUDIO_DW=24, SLOT_BITS=32).
module tb_i2s_rx;

    logic        sclk = 1'b0;
    logic        rst;
    logic        lrclk;
    logic        sdata;
    logic [23:0] left_chan;
    logic [23:0] right_chan;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic        frame_err;

    int testsRun    = 0;
    int testsFailed = 0;
    int errCount    = 0;
    int errBase;

    logic [31:0] vtrace;
    logic        snapValid;
    logic [23:0] snapLeft;
    logic [23:0] snapRight;
    logic        anyValid;

    i2s_rx #(.AUDIO_DW(24), .SLOT_BITS(32)) dut (
        .sclk       (sclk),
        .rst        (rst),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .left_chan  (left_chan),
        .right_chan (right_chan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .frame_err  (frame_err)
    );

    always #5 sclk = ~sclk;

    always @(negedge sclk) begin
        if (frame_err === 1'b1) errCount <= errCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one frame on falling sclk; slot bit 0 is the delay bit, pad bits are 1s.
    task automatic applyStimulus(input logic [23:0] lw, input logic [23:0] rw,
                                 input int llen, input int rlen, input int rstAt);
        logic [23:0] w;
        int          len;
        vtrace = '0;
        snapValid = 1'b0;
        for (int ch = 0; ch < 2; ch++) begin
            w   = (ch == 1) ? rw : lw;
            len = (ch == 1) ? rlen : llen;
            for (int i = 0; i < len; i++) begin
                @(negedge sclk);
                if (ch == 1) begin
                    vtrace[i] = out_valid;
                    if (i == 26) begin
                        snapValid = out_valid;
                        snapLeft  = left_chan;
                        snapRight = right_chan;
                    end
                end
                if (ch == 0 && i == rstAt) rst = 1'b1;
                if (ch == 0 && i == rstAt + 2) rst = 1'b0;
                lrclk = (ch == 1);
                sdata = (i >= 1 && i <= 24) ? w[24 - i] : 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        lrclk = 1'b1;
        sdata = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge sclk);
        rst = 1'b0;
        @(negedge sclk);
        checkOutput("reset left", 32'(left_chan), 32'h0);
        checkOutput("reset right", 32'(right_chan), 32'h0);
        checkOutput("reset valid", 32'(out_valid), 32'h0);
        checkOutput("reset overrun", 32'(overrun), 32'h0);
        checkOutput("reset frame_err", 32'(frame_err), 32'h0);

        // Tail of a right slot with no preceding left slot
        anyValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sclk);
            anyValid = anyValid | out_valid;
            lrclk = 1'b1;
            sdata = i[0];
        end
        checkOutput("midright no output", 32'(anyValid), 32'h0);

        for (int f = 0; f < 2; f++) begin
            applyStimulus(24'hA5A5A5, 24'h5A5A5A, 32, 32, -1);
            checkOutput("std valid before", 32'(vtrace[25]), 32'h0);
            checkOutput("std valid pulse", 32'(vtrace[26]), 32'h1);
            checkOutput("std valid after", 32'(vtrace[27]), 32'h0);
            checkOutput("std left", 32'(snapLeft), 32'hA5A5A5);
            checkOutput("std right", 32'(snapRight), 32'h5A5A5A);
        end

        out_ready = 1'b0;
        applyStimulus(24'h000001, 24'h800000, 32, 32, -1);
        checkOutput("stall first valid", 32'(vtrace[26]), 32'h1);
        applyStimulus(24'h111111, 24'h222222, 32, 32, -1);
        applyStimulus(24'h333333, 24'h444444, 32, 32, -1);
        checkOutput("stall valid held", 32'(out_valid), 32'h1);
        checkOutput("stall left", 32'(left_chan), 32'h000001);
        checkOutput("stall right", 32'(right_chan), 32'h800000);
        checkOutput("stall overrun", 32'(overrun), 32'h1);
        out_ready = 1'b1;
        @(negedge sclk);
        checkOutput("accept drops valid", 32'(out_valid), 32'h0);
        checkOutput("overrun sticky", 32'(overrun), 32'h1);

        // Reset during bit 10 of a left slot; the remainder of that frame must be discarded
        applyStimulus(24'hFFFFFF, 24'h777777, 32, 32, 11);
        checkOutput("rst no frame", 32'(|vtrace), 32'h0);
        checkOutput("rst left zero", 32'(left_chan), 32'h0);
        checkOutput("rst right zero", 32'(right_chan), 32'h0);
        checkOutput("rst overrun clear", 32'(overrun), 32'h0);
        applyStimulus(24'h123456, 24'h654321, 32, 32, -1);
        checkOutput("post rst valid", 32'(snapValid), 32'h1);
        checkOutput("post rst left", 32'(snapLeft), 32'h123456);
        checkOutput("post rst right", 32'(snapRight), 32'h654321);

        // Shortened left slot followed by a good frame, starting from a clean reset
        @(negedge sclk);
        rst = 1'b1;
        lrclk = 1'b1;
        repeat (2) @(negedge sclk);
        rst = 1'b0;
        repeat (4) @(negedge sclk);
        errBase = errCount;
        applyStimulus(24'h0F0F0F, 24'hF0F0F0, 30, 32, -1);
`ifdef I2S_RX_FRAME_CHECK_EN
        checkOutput("short frame dropped", 32'(snapValid), 32'h0);
`else
        checkOutput("short frame valid", 32'(snapValid), 32'h1);
        checkOutput("short frame left", 32'(snapLeft), 32'h0F0F0F);
        checkOutput("short frame right", 32'(snapRight), 32'hF0F0F0);
`endif
        applyStimulus(24'h2468AC, 24'h13579B, 32, 32, -1);
        checkOutput("resync valid", 32'(snapValid), 32'h1);
        checkOutput("resync left", 32'(snapLeft), 32'h2468AC);
        checkOutput("resync right", 32'(snapRight), 32'h13579B);
`ifdef I2S_RX_FRAME_CHECK_EN
        checkOutput("frame_err pulses", 32'(errCount - errBase), 32'h1);
`else
        checkOutput("frame_err pulses", 32'(errCount - errBase), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
